// File: rtl/pmp_pkg.sv
// Shared types, Q2.14 phase constants and the quarter-wave sine table generator
// used by the 4-step phase-shift fringe generator.
package pmp_pkg;

    typedef logic signed [15:0] phase_t;

    // Quadrant of the wrapped phase (phase bits 14:13).
    typedef enum logic [1:0] {
        QUAD_0 = 2'd0,
        QUAD_1 = 2'd1,
        QUAD_2 = 2'd2,
        QUAD_3 = 2'd3
    } quad_t;

    localparam phase_t      PHASE_ONE       = 16'sd16384;
    localparam logic [15:0] NOISE_CODE_DEF  = 16'b10100000_00000000;
    localparam int          SIN_ONE         = 32767;
    localparam int          ROUND_HALF      = 16384;
    localparam real         PI              = 3.14159265358979323846;

    // T[j] = round(32767 * sin(j*pi/(2N))), N = 2^aw; argument range is [0, pi/2].
    function automatic logic [15:0] quarter_sin_entry(input int j, input int aw);
        real ang;
        ang = real'(j) * PI / (2.0 * real'(1 << aw));
        return 16'($rtoi(real'(SIN_ONE) * $sin(ang) + 0.5));
    endfunction

endpackage

// File: rtl/quarter_sin_rom.sv
// Quarter-wave sine table, N+1 entries x 16 bit, with two registered read ports
// sharing one array.
module quarter_sin_rom
    import pmp_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rd_en,
    input  logic [AW:0]   addr_a,
    input  logic [AW:0]   addr_b,
    output logic [15:0]   data_a,
    output logic [15:0]   data_b
);

    localparam int N = 1 << AW;

    logic [15:0] rom [0:N];

    genvar gi;
    generate
        for (gi = 0; gi <= N; gi++) begin : g_rom_init
            assign rom[gi] = quarter_sin_entry(gi, AW);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rd_en) begin
            data_a <= rom[addr_a];
            data_b <= rom[addr_b];
        end
    end

endmodule

// File: rtl/rel_phase_4steps_gen.sv
// 4-step phase-shift fringe generator: (phi, A, B) -> I_k = B + A*cos(phi + (k-1)*pi/2).
// Optional macro PMP_GEN_NOISE_PASS_EN: phase_i == NOISE_CODE yields zero modulation.
module rel_phase_4steps_gen
    import pmp_pkg::*;
#(
    parameter int          LUT_AW     = 8,
    parameter int          PIX_W      = 8,
    parameter logic [15:0] NOISE_CODE = NOISE_CODE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld_i,
    input  logic [15:0]      phase_i,
    input  logic [PIX_W-1:0] amp_i,
    input  logic [PIX_W-1:0] offset_i,
    input  logic             last_i,
    output logic             vld_o,
    output logic [PIX_W-1:0] pixel1_o,
    output logic [PIX_W-1:0] pixel2_o,
    output logic [PIX_W-1:0] pixel3_o,
    output logic [PIX_W-1:0] pixel4_o,
    output logic             last_o
);

    localparam int N  = 1 << LUT_AW;
    localparam int PW = PIX_W + 17;
    localparam int TW = PIX_W + 2;
    localparam logic signed [TW-1:0] PIX_MAX = TW'((1 << PIX_W) - 1);

`ifdef PMP_GEN_NOISE_PASS_EN
    localparam bit NOISE_PASS = 1'b1;
`else
    localparam bit NOISE_PASS = 1'b0;
`endif

    function automatic logic [PIX_W-1:0] sat_pix(input logic signed [TW-1:0] v);
        if (v < 0)
            return '0;
        else if (v > PIX_MAX)
            return PIX_MAX[PIX_W-1:0];
        else
            return v[PIX_W-1:0];
    endfunction

    // S1: input registers, phase split into quadrant and table index
    logic              s1_vld_reg;
    quad_t             s1_quad_reg;
    logic [LUT_AW-1:0] s1_idx_reg;
    logic [PIX_W-1:0]  s1_amp_reg, s1_off_reg;
    logic              s1_last_reg, s1_noise_reg;

    always_ff @(posedge clk) begin
        if (rst)
            s1_vld_reg <= 1'b0;
        else
            s1_vld_reg <= vld_i;
        if (vld_i) begin
            s1_quad_reg  <= quad_t'(phase_i[14:13]);
            s1_idx_reg   <= phase_i[12:13-LUT_AW];
            s1_amp_reg   <= amp_i;
            s1_off_reg   <= offset_i;
            s1_last_reg  <= last_i;
            s1_noise_reg <= NOISE_PASS && (phase_i == NOISE_CODE);
        end
    end

    // S2: table lookups T[i] and T[N-i]
    logic [LUT_AW:0] addr_a, addr_b;
    logic [15:0]     tab_a, tab_b;

    assign addr_a = {1'b0, s1_idx_reg};
    assign addr_b = (LUT_AW+1)'(N) - addr_a;

    quarter_sin_rom #(
        .AW (LUT_AW)
    ) u_rom (
        .clk    (clk),
        .rd_en  (s1_vld_reg),
        .addr_a (addr_a),
        .addr_b (addr_b),
        .data_a (tab_a),
        .data_b (tab_b)
    );

    logic             s2_vld_reg;
    quad_t            s2_quad_reg;
    logic [PIX_W-1:0] s2_amp_reg, s2_off_reg;
    logic             s2_last_reg, s2_noise_reg;

    always_ff @(posedge clk) begin
        if (rst)
            s2_vld_reg <= 1'b0;
        else
            s2_vld_reg <= s1_vld_reg;
        if (s1_vld_reg) begin
            s2_quad_reg  <= s1_quad_reg;
            s2_amp_reg   <= s1_amp_reg;
            s2_off_reg   <= s1_off_reg;
            s2_last_reg  <= s1_last_reg;
            s2_noise_reg <= s1_noise_reg;
        end
    end

    // S3: fold quarter-wave values into full-circle sin/cos (Q1.15)
    logic signed [15:0] sin_next, cos_next;
    logic signed [15:0] ta_s, tb_s;

    assign ta_s = $signed(tab_a);
    assign tb_s = $signed(tab_b);

    always_comb begin
        sin_next = '0;
        cos_next = '0;
        case (s2_quad_reg)
            QUAD_0: begin sin_next =  ta_s; cos_next =  tb_s; end
            QUAD_1: begin sin_next =  tb_s; cos_next = -ta_s; end
            QUAD_2: begin sin_next = -ta_s; cos_next = -tb_s; end
            QUAD_3: begin sin_next = -tb_s; cos_next =  ta_s; end
            default: begin sin_next = '0; cos_next = '0; end
        endcase
    end

    logic               s3_vld_reg;
    logic signed [15:0] s3_sin_reg, s3_cos_reg;
    logic [PIX_W-1:0]   s3_amp_reg, s3_off_reg;
    logic               s3_last_reg, s3_noise_reg;

    always_ff @(posedge clk) begin
        if (rst)
            s3_vld_reg <= 1'b0;
        else
            s3_vld_reg <= s2_vld_reg;
        if (s2_vld_reg) begin
            s3_sin_reg   <= sin_next;
            s3_cos_reg   <= cos_next;
            s3_amp_reg   <= s2_amp_reg;
            s3_off_reg   <= s2_off_reg;
            s3_last_reg  <= s2_last_reg;
            s3_noise_reg <= s2_noise_reg;
        end
    end

    // S4: scale by amplitude and round Q1.15 back to pixel units (half up)
    logic signed [PW-1:0] amp_ext, prod_c, prod_s;
    logic signed [TW-1:0] tc_next, ts_next;

    always_comb begin
        amp_ext = PW'($signed({1'b0, s3_amp_reg}));
        prod_c  = amp_ext * PW'(s3_cos_reg);
        prod_s  = amp_ext * PW'(s3_sin_reg);
        tc_next = TW'((prod_c + PW'(ROUND_HALF)) >>> 15);
        ts_next = TW'((prod_s + PW'(ROUND_HALF)) >>> 15);
        if (s3_noise_reg) begin
            tc_next = '0;
            ts_next = '0;
        end
    end

    logic                 s4_vld_reg;
    logic signed [TW-1:0] s4_tc_reg, s4_ts_reg;
    logic [PIX_W-1:0]     s4_off_reg;
    logic                 s4_last_reg;

    always_ff @(posedge clk) begin
        if (rst)
            s4_vld_reg <= 1'b0;
        else
            s4_vld_reg <= s3_vld_reg;
        if (s3_vld_reg) begin
            s4_tc_reg   <= tc_next;
            s4_ts_reg   <= ts_next;
            s4_off_reg  <= s3_off_reg;
            s4_last_reg <= s3_last_reg;
        end
    end

    // S5: combine with offset and clamp to the pixel range
    logic signed [TW-1:0] off_s, sum1, sum2, sum3, sum4;

    always_comb begin
        off_s = $signed({2'b00, s4_off_reg});
        sum1  = off_s + s4_tc_reg;
        sum2  = off_s - s4_ts_reg;
        sum3  = off_s - s4_tc_reg;
        sum4  = off_s + s4_ts_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_o    <= 1'b0;
            last_o   <= 1'b0;
            pixel1_o <= '0;
            pixel2_o <= '0;
            pixel3_o <= '0;
            pixel4_o <= '0;
        end else begin
            vld_o  <= s4_vld_reg;
            last_o <= s4_vld_reg && s4_last_reg;
            if (s4_vld_reg) begin
                pixel1_o <= sat_pix(sum1);
                pixel2_o <= sat_pix(sum2);
                pixel3_o <= sat_pix(sum3);
                pixel4_o <= sat_pix(sum4);
            end
        end
    end

endmodule
